pulse_width_meter: RTL and testbench
====================================

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, arm request; sampled only in IDLE.
REQ-004 SHALL have port echo_in, input, 1, asynchronous pulse to be measured.
REQ-005 SHALL have port timeout_lim, input, 32 (int unsigned), cycle limit for a wait or a measurement; 0 disables the timeout.
REQ-006 SHALL have port width, output, 32 (int unsigned), last measured high time in clk cycles; held until the next valid measurement.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when width is updated.
REQ-008 SHALL have port timeout, output, 1, one-cycle pulse when an operation is abandoned on timeout.
REQ-009 SHALL have port busy, output, 1, high in WAIT_RISE and MEASURE.

Function
REQ-010 SHALL pass echo_in through a 2-flop synchronizer to give s, and SHALL register s once more to give p; rise = s & ~p, fall = ~s & p.
REQ-011 SHALL implement the FSM states IDLE, WAIT_RISE and MEASURE, with busy = (state != IDLE).
REQ-012 IDLE: start=1 SHALL go to WAIT_RISE next cycle with wait_cnt <= 0; edges on s in IDLE SHALL be ignored.
REQ-013 WAIT_RISE: rise SHALL go to MEASURE with cnt <= 1; otherwise wait_cnt SHALL increment by 1.
REQ-014 WAIT_RISE: if timeout_lim != 0, no rise, and wait_cnt == timeout_lim-1, the block SHALL pulse timeout and go to IDLE; the timeout pulse appears timeout_lim cycles after the start cycle.
REQ-015 MEASURE: s=1 SHALL increment cnt, saturating at 32'hFFFF_FFFF.
REQ-016 MEASURE: s=0 SHALL do all of width <= cnt, valid <= 1, go to IDLE; result: an echo_in high for N clk cycles gives width = N.
REQ-017 MEASURE: if timeout_lim != 0, s=1 and cnt == timeout_lim, the block SHALL pulse timeout, go to IDLE, and leave width and valid unchanged.
REQ-018 Latency: valid SHALL assert exactly 3 clk cycles after the first low sample of echo_in following the pulse (2 sync + 1 registered).
REQ-019 start while busy=1 SHALL be ignored, with no restart and no counter clear.
REQ-020 If s is already high when WAIT_RISE is entered, the block SHALL wait for s to fall and rise again; it SHALL NOT measure a partial pulse.
REQ-021 valid and timeout SHALL never be asserted in the same cycle; each SHALL be high for at most 1 cycle per operation.
REQ-022 After valid or timeout the block SHALL be in IDLE; start may be asserted in the cycle right after either pulse.
REQ-023 width SHALL be updated only on valid; counters are internal and not visible.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, width=0, valid=0, timeout=0, busy=0, cnt=0, wait_cnt=0, and clear both synchronizer flops and p.
REQ-025 rst asserted mid-measurement SHALL discard the operation with no valid or timeout pulse; after release the block SHALL require a new start.

Verification
REQ-026 Basic: timeout_lim=0, start 1 cycle, then echo_in high 100 cycles -> one valid pulse, width=100, timeout never set.
REQ-027 Wait timeout: timeout_lim=50, start, echo_in held low -> timeout pulse 50 cycles after the start cycle, busy=0 next, width unchanged.
REQ-028 Measure timeout: timeout_lim=20, start, echo_in high 40 cycles -> timeout pulse with no valid; width keeps its prior value (0 after reset).
REQ-029 Echo high at arm: echo_in high, start, echo_in low 5 cycles then high 7 cycles -> valid, width=7.
REQ-030 Ignored start: start pulsed again during MEASURE of a 30-cycle pulse -> single valid, width=30, IDLE afterwards.
REQ-031 Reset mid-operation: rst pulse at cycle 10 of a 60-cycle pulse -> valid=0, width=0, busy=0; no output activity until the next start.

Source files
------------

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures how long echo_in stays high, in clk cycles.
// After start it waits for a clean rising edge, counts the high time and
// reports it on width/valid. A non-zero timeout_lim bounds both the wait
// for the edge and the measurement itself.

module pulse_width_meter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo_in,
    input  logic [31:0] timeout_lim,
    output logic [31:0] width,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [31:0] r_cnt;
    logic [31:0] r_waitCnt;
    logic [31:0] r_width;
    logic        r_valid;
    logic        r_timeout;
    logic        r_busy;

    logic        w_rise;
    logic        w_limOn;
    logic        w_waitDone;
    logic        w_measDone;
    logic        w_cntMax;

    // r_sync2 is the synchronized echo; r_prev delays it one more cycle so
    // a rising edge shows up as a single-cycle mismatch between the two.
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_limOn    = (timeout_lim != 32'd0);
    assign w_waitDone = (r_waitCnt == (timeout_lim - 32'd1));
    assign w_measDone = (r_cnt == timeout_lim);
    assign w_cntMax   = (r_cnt == 32'hFFFF_FFFF);

    assign width   = r_width;
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign busy    = r_busy;

    // Bring the asynchronous echo into the clk domain and keep the previous
    // synchronized sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= echo_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Control FSM with registered result, pulse and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 32'd0;
            r_waitCnt <= 32'd0;
            r_width   <= 32'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= WAIT_RISE;
                        r_waitCnt <= 32'd0;
                        r_busy    <= 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_cnt   <= 32'd1;
                    end else if (w_limOn && w_waitDone) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 32'd1;
                    end
                end
                MEASURE: begin
                    if (r_sync2) begin
                        if (w_limOn && w_measDone) begin
                            r_state   <= IDLE;
                            r_timeout <= 1'b1;
                            r_busy    <= 1'b0;
                        end else if (!w_cntMax) begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end else begin
                        r_width <= r_cnt;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Testbench for pulse_width_meter: a table of directed operations, a
// reset-in-the-middle sequence, then random operations checked against an
// arithmetic model of when valid/timeout must fire and what width must be.

module tb_pulse_width_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        echoIn;
    logic [31:0] timeoutLim;
    logic [31:0] width;
    logic        valid;
    logic        timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int modelWidth = 0;

    // kind: 1 = valid expected, 2 = timeout expected
    typedef struct {
        int lim;
        int d;
        int n;
        int pre;
        int restartAt;
        int expKind;
        int expEdge;
        int expWidth;
    } vec_t;

    vec_t vecs[11];

    pulse_width_meter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .echo_in    (echoIn),
        .timeout_lim(timeoutLim),
        .width      (width),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation. Edge k is the k-th rising edge after start is first
    // driven; echo is high for edges d..d+n-1 (and at edge 0 when pre is set).
    task automatic applyStimulus(input int lim, input int d, input int n, input int pre,
                                 input int restartAt, output int nValid, output int nTo,
                                 output int vEdge, output int tEdge, output int busy0,
                                 output int busyEnd, output int both);
        int lastK;
        nValid = 0; nTo = 0; vEdge = -1; tEdge = -1; busy0 = 0; both = 0;
        lastK = d + n + lim + 8;
        timeoutLim = lim;
        if (pre != 0) begin
            @(negedge clk);
            echoIn = 1'b1;
            repeat (3) @(negedge clk);
        end
        for (int k = 0; k <= lastK; k++) begin
            @(negedge clk);
            start  = (k == 0) || (restartAt > 0 && k == restartAt);
            echoIn = (pre != 0 && k < 1) || (k >= d && k < d + n);
            @(posedge clk);
            #1;
            if (valid) begin nValid++; vEdge = k; end
            if (timeout) begin nTo++; tEdge = k; end
            if (valid && timeout) both = 1;
            if (k == 0) busy0 = busy;
        end
        busyEnd = busy;
        @(negedge clk);
        start  = 1'b0;
        echoIn = 1'b0;
    endtask

    // Outcome of an operation from the block's rules: the rise is seen two
    // synchronizer edges after echo is first sampled high, the wait gives up
    // at edge lim, and a measurement gives up once more than lim high cycles
    // have been counted.
    task automatic modelOp(input int lim, input int d, input int n,
                           output int kind, output int evEdge);
        if (lim != 0 && (n == 0 || d + 2 > lim)) begin
            kind = 2; evEdge = lim;
        end else if (lim != 0 && n > lim) begin
            kind = 2; evEdge = d + 2 + lim;
        end else begin
            kind = 1; evEdge = d + n + 2;
        end
    endtask

    task automatic runAndCheck(input string tag, input vec_t v);
        int nValid, nTo, vEdge, tEdge, busy0, busyEnd, both;
        applyStimulus(v.lim, v.d, v.n, v.pre, v.restartAt,
                      nValid, nTo, vEdge, tEdge, busy0, busyEnd, both);
        checkOutput({tag, " busyAfterStart"}, busy0, 1);
        checkOutput({tag, " validCount"}, nValid, (v.expKind == 1) ? 1 : 0);
        checkOutput({tag, " timeoutCount"}, nTo, (v.expKind == 2) ? 1 : 0);
        if (v.expKind == 1) checkOutput({tag, " validEdge"}, vEdge, v.expEdge);
        else                checkOutput({tag, " timeoutEdge"}, tEdge, v.expEdge);
        checkOutput({tag, " width"}, width, v.expWidth);
        checkOutput({tag, " busyEnd"}, busyEnd, 0);
        checkOutput({tag, " bothPulses"}, both, 0);
    endtask

    initial begin
        int nAct, kind, evEdge;
        vec_t v;

        vecs[0]  = '{20, 2, 40, 0, 0,  2, 24,   0};
        vecs[1]  = '{0,  3, 100, 0, 0, 1, 105, 100};
        vecs[2]  = '{50, 0, 0,  0, 0,  2, 50,  100};
        vecs[3]  = '{20, 4, 20, 0, 0,  1, 26,   20};
        vecs[4]  = '{20, 4, 21, 0, 0,  2, 26,   20};
        vecs[5]  = '{10, 8, 5,  0, 0,  1, 15,    5};
        vecs[6]  = '{10, 9, 5,  0, 0,  2, 10,    5};
        vecs[7]  = '{0,  1, 1,  0, 0,  1, 4,     1};
        vecs[8]  = '{1,  0, 0,  0, 0,  2, 1,     1};
        vecs[9]  = '{0,  2, 30, 0, 15, 1, 34,   30};
        vecs[10] = '{0,  6, 7,  1, 0,  1, 15,    7};

        rst = 1'b1; start = 1'b0; echoIn = 1'b0; timeoutLim = 32'd0;
        #1;
        checkOutput("reset width", width, 0);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset timeout", timeout, 0);
        checkOutput("reset busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i]);
            modelWidth = vecs[i].expWidth;
        end

        // Reset in the middle of a 60-cycle pulse, then confirm silence.
        nAct = 0;
        timeoutLim = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            start  = (k == 0);
            echoIn = (k >= 2 && k < 62);
            if (k == 14) begin
                rst = 1'b1;
                #1;
                checkOutput("midReset valid", valid, 0);
                checkOutput("midReset width", width, 0);
                checkOutput("midReset busy", busy, 0);
            end
            if (k == 16) rst = 1'b0;
            @(posedge clk);
            #1;
            if (k > 14 && (valid || timeout || busy)) nAct++;
        end
        checkOutput("postReset activity", nAct, 0);
        checkOutput("postReset width", width, 0);
        modelWidth = 0;
        @(negedge clk);
        echoIn = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            v.lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40);
            v.d = $urandom_range(1, 30);
            v.n = $urandom_range(1, 50);
            v.pre = 0;
            v.restartAt = 0;
            modelOp(v.lim, v.d, v.n, kind, evEdge);
            if (kind == 1) modelWidth = v.n;
            v.expKind = kind;
            v.expEdge = evEdge;
            v.expWidth = modelWidth;
            runAndCheck($sformatf("rand%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
